// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI-Lite command master.
package axil_cmd_master_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Cycles a transaction may stay outstanding before it is abandoned
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Width of a counter that must hold 0..t inclusive; never narrower than 1 bit
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/axil_cmd_master_timeout_cnt.sv
// Per-transaction watchdog. Counts busy cycles from command accept and
// saturates at TIMEOUT_CYCLES. 'expired' is raised in the busy cycle that
// carries the count up to TIMEOUT_CYCLES, so the owner can abandon the
// transaction at that edge and have valids low on the following cycle.
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module axil_timeout_cnt
    import axil_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic aclk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam bit            ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;

    // Busy-cycle counter: cleared on accept, held at LIMIT once reached
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Extra bit keeps the look-ahead compare free of wrap-around
    assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign expired = ENABLED && en && (cnt_inc >= {1'b0, LIMIT});

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master driven by a simple valid/ready command
// port. One command is accepted in IDLE, issued as a write (AW+W then B) or
// a read (AR then R), and its result is presented on the response port.
// A busy-cycle watchdog abandons transactions the slave never completes.
module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADDR_W         = 32
) (
    input  logic              aclk,
    input  logic              resetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,

    output logic              m_axi_lite_awvalid,
    input  logic              m_axi_lite_awready,
    output logic [ADDR_W-1:0] m_axi_lite_awaddr,
    output logic              m_axi_lite_wvalid,
    input  logic              m_axi_lite_wready,
    output logic [31:0]       m_axi_lite_wdata,
    output logic [3:0]        m_axi_lite_wstrb,
    input  logic              m_axi_lite_bvalid,
    output logic              m_axi_lite_bready,
    input  logic [1:0]        m_axi_lite_bresp,
    output logic              m_axi_lite_arvalid,
    input  logic              m_axi_lite_arready,
    output logic [ADDR_W-1:0] m_axi_lite_araddr,
    input  logic              m_axi_lite_rvalid,
    output logic              m_axi_lite_rready,
    input  logic [31:0]       m_axi_lite_rdata,
    input  logic [1:0]        m_axi_lite_rresp
);

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                timeout_q, timeout_d;

    logic                accept;
    logic                busy;
    logic                tmo_expired;
    logic                abort;
    logic                aw_done;
    logic                w_done;

    assign accept = (state_q == ST_IDLE) && cmd_valid;
    assign busy   = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                    (state_q == ST_RD_REQ)  || (state_q == ST_RD_DATA);

    // A channel is finished once its valid has dropped or it handshakes now
    assign aw_done = !awvalid_q || m_axi_lite_awready;
    assign w_done  = !wvalid_q  || m_axi_lite_wready;

    axil_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .aclk    (aclk),
        .resetn  (resetn),
        .clr     (accept),
        .en      (busy),
        .expired (tmo_expired)
    );

    // State, channel valids and captured command/response registers
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and next-register values; a completing handshake always
    // wins over a watchdog expiry in the same cycle
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        abort     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    timeout_d = 1'b0;
                    if (cmd_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end

            ST_WR_REQ: begin
                if (awvalid_q && m_axi_lite_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_lite_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d = ST_WR_RESP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (m_axi_lite_bvalid) begin
                    resp_d  = m_axi_lite_bresp;
                    rdata_d = '0;
                    state_d = ST_RSP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end

            ST_RD_REQ: begin
                if (m_axi_lite_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end

            ST_RD_DATA: begin
                if (m_axi_lite_rvalid) begin
                    rdata_d = m_axi_lite_rdata;
                    resp_d  = m_axi_lite_rresp;
                    state_d = ST_RSP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end

            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            rdata_d   = '0;
            resp_d    = RESP_SLVERR;
            timeout_d = 1'b1;
            state_d   = ST_RSP;
        end
    end

    assign cmd_ready          = resetn && (state_q == ST_IDLE);

    assign rsp_valid          = (state_q == ST_RSP);
    assign rsp_rdata          = rdata_q;
    assign rsp_resp           = resp_q;
    assign rsp_timeout        = timeout_q;

    assign m_axi_lite_awvalid = awvalid_q;
    assign m_axi_lite_awaddr  = addr_q;
    assign m_axi_lite_wvalid  = wvalid_q;
    assign m_axi_lite_wdata   = wdata_q;
    assign m_axi_lite_wstrb   = 4'hF;
    assign m_axi_lite_bready  = (state_q == ST_WR_RESP);
    assign m_axi_lite_arvalid = arvalid_q;
    assign m_axi_lite_araddr  = addr_q;
    assign m_axi_lite_rready  = (state_q == ST_RD_DATA);

endmodule
